// File: rtl/snek_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snek_pkg
// Description : Shared types and constants for the snake engine: direction
//               codes, FSM state encoding, reverse-direction helper and the
//               default grid geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package snek_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam int DEF_GRID_W   = 32;
  localparam int DEF_GRID_H   = 24;
  localparam int DEF_MAX_LEN  = 64;
  localparam int DEF_INIT_LEN = 3;
  localparam int DEF_WRAP     = 1;

  // Left/right and up/down differ only in bit 0, so flipping it reverses.
  function automatic dir_e reverse_of(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snek_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : snek_engine_if
// Description : Control, food, renderer-query and status signals of the snake
//               engine. Optional macro SNEK_SCORE_EN adds a 16-bit score.
// Revision    : 1.0 - initial release
// ============================================================================
interface snek_engine_if #(
  parameter int XW = 5,
  parameter int YW = 5,
  parameter int LW = 7
);
  logic          tick;
  logic          restart;
  logic          dir_valid;
  logic [1:0]    dir_req;
  logic          food_valid;
  logic [XW-1:0] food_h;
  logic [YW-1:0] food_v;
  logic [XW-1:0] query_h;
  logic [YW-1:0] query_v;
  logic          query_hit;
  logic [XW-1:0] head_h;
  logic [YW-1:0] head_v;
  logic [LW-1:0] length;
  logic          eaten;
  logic          game_over;
  logic          busy;
`ifdef SNEK_SCORE_EN
  logic [15:0]   score;
`endif

  modport master (
    output tick, restart, dir_valid, dir_req, food_valid, food_h, food_v,
           query_h, query_v,
`ifdef SNEK_SCORE_EN
    input  score,
`endif
    input  query_hit, head_h, head_v, length, eaten, game_over, busy
  );

  modport slave (
    input  tick, restart, dir_valid, dir_req, food_valid, food_h, food_v,
           query_h, query_v,
`ifdef SNEK_SCORE_EN
    output score,
`endif
    output query_hit, head_h, head_v, length, eaten, game_over, busy
  );
endinterface
`default_nettype wire

// File: rtl/snek_ring.sv
`default_nettype none
// ============================================================================
// Module      : snek_ring
// Description : Circular buffer of body positions. The head pointer marks the
//               newest cell, the tail pointer the oldest. Writes land one slot
//               past the head; advancing the tail drops the oldest cell.
// Revision    : 1.0 - initial release
// ============================================================================
module snek_ring
  import snek_pkg::*;
#(
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int INIT_LEN = DEF_INIT_LEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init,
  input  logic          i_wr,
  input  logic [XW-1:0] i_wr_h,
  input  logic [YW-1:0] i_wr_v,
  input  logic          i_adv,
  output logic [XW-1:0] o_tail_h,
  output logic [YW-1:0] o_tail_v
);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [XW-1:0] r_mem_h [MAX_LEN];
  logic [YW-1:0] r_mem_v [MAX_LEN];
  logic [PW-1:0] r_head_ptr;
  logic [PW-1:0] r_tail_ptr;
  logic [PW-1:0] w_wr_ptr;

  // Starting body: slot 0 is the tail, slot INIT_LEN-1 the head, left to right.
  function automatic logic [XW-1:0] init_col(input int i);
    return (i < INIT_LEN) ? XW'(GRID_W / 2 - INIT_LEN + 1 + i) : '0;
  endfunction

  assign w_wr_ptr = r_head_ptr + 1'b1;
  assign o_tail_h = r_mem_h[r_tail_ptr];
  assign o_tail_v = r_mem_v[r_tail_ptr];

  // Pointer and storage update; restart reloads the starting body in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_ptr <= PW'(INIT_LEN - 1);
      r_tail_ptr <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_mem_h[i] <= init_col(i);
        r_mem_v[i] <= YW'(GRID_H / 2);
      end
    end else if (i_init) begin
      r_head_ptr <= PW'(INIT_LEN - 1);
      r_tail_ptr <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        r_mem_h[i] <= init_col(i);
        r_mem_v[i] <= YW'(GRID_H / 2);
      end
    end else begin
      if (i_wr) begin
        r_mem_h[w_wr_ptr] <= i_wr_h;
        r_mem_v[w_wr_ptr] <= i_wr_v;
        r_head_ptr        <= w_wr_ptr;
      end
      if (i_adv) begin
        r_tail_ptr <= r_tail_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snek_engine.sv
`default_nettype none
// ============================================================================
// Module      : snek_engine
// Description : Snake state engine. Per tick: move the head, reject reversals,
//               detect wall/self collision, eat and grow. Owns the occupancy
//               bitmap, the step FSM and the direction latch.
//               Optional macro SNEK_SCORE_EN adds a saturating eaten counter.
// Revision    : 1.0 - initial release
// ============================================================================
module snek_engine
  import snek_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int WRAP     = DEF_WRAP
) (
  input  logic    clk,
  input  logic    rst,
  snek_engine_if.slave bus
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int CW    = $clog2(CELLS);

  state_e        r_state, w_state_nx;
  dir_e          r_dir, r_pend;
  logic [XW-1:0] r_head_h, r_nx_h, w_nx_h, w_tail_h;
  logic [YW-1:0] r_head_v, r_nx_v, w_nx_v, w_tail_v;
  logic          r_wall, w_wall;
  logic          r_hit, r_grow, r_coll, w_hit, w_grow, w_coll;
  logic [LW-1:0] r_len;
  logic          r_eaten, r_go;
  logic [CELLS-1:0] r_bitmap;
  logic          w_commit_ok, w_q_in;

  function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] h, input logic [YW-1:0] v);
    return CW'(int'(v) * GRID_W + int'(h));
  endfunction

  function automatic logic [CELLS-1:0] init_map();
    logic [CELLS-1:0] m;
    m = '0;
    for (int i = 0; i < INIT_LEN; i++) m[(GRID_H / 2) * GRID_W + GRID_W / 2 - i] = 1'b1;
    return m;
  endfunction

  assign w_commit_ok = (r_state == ST_COMMIT) && !r_coll;

  snek_ring #(
    .MAX_LEN(MAX_LEN), .XW(XW), .YW(YW),
    .GRID_W(GRID_W), .GRID_H(GRID_H), .INIT_LEN(INIT_LEN)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .i_init   (bus.restart),
    .i_wr     (w_commit_ok),
    .i_wr_h   (r_nx_h),
    .i_wr_v   (r_nx_v),
    .i_adv    (w_commit_ok && !r_grow),
    .o_tail_h (w_tail_h),
    .o_tail_v (w_tail_v)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  // Next state: restart aborts any step; ticks are only taken idle and alive.
  always_comb begin
    w_state_nx = r_state;
    if (bus.restart) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.tick && !r_go) w_state_nx = ST_STEP;
        ST_STEP:   w_state_nx = ST_CHECK;
        ST_CHECK:  w_state_nx = ST_COMMIT;
        ST_COMMIT: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Candidate head one cell along the direction about to be committed.
  always_comb begin
    w_nx_h = r_head_h;
    w_nx_v = r_head_v;
    w_wall = 1'b0;
    case (r_pend)
      DIR_LEFT:
        if (r_head_h == '0) begin
          if (WRAP != 0) w_nx_h = XW'(GRID_W - 1); else w_wall = 1'b1;
        end else w_nx_h = r_head_h - 1'b1;
      DIR_RIGHT:
        if (r_head_h == XW'(GRID_W - 1)) begin
          if (WRAP != 0) w_nx_h = '0; else w_wall = 1'b1;
        end else w_nx_h = r_head_h + 1'b1;
      DIR_UP:
        if (r_head_v == '0) begin
          if (WRAP != 0) w_nx_v = YW'(GRID_H - 1); else w_wall = 1'b1;
        end else w_nx_v = r_head_v - 1'b1;
      DIR_DOWN:
        if (r_head_v == YW'(GRID_H - 1)) begin
          if (WRAP != 0) w_nx_v = '0; else w_wall = 1'b1;
        end else w_nx_v = r_head_v + 1'b1;
    endcase
  end

  // Growth and collision; the tail cell is free unless the snake is growing.
  always_comb begin
    w_hit  = bus.food_valid && (r_nx_h == bus.food_h) && (r_nx_v == bus.food_v);
    w_grow = w_hit && (int'(r_len) < MAX_LEN);
    w_coll = r_wall || (r_bitmap[cell_idx(r_nx_h, r_nx_v)] &&
             !((r_nx_h == w_tail_h) && (r_nx_v == w_tail_v) && !w_grow));
  end

  // Direction latch: reversals of the committed direction are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir  <= DIR_RIGHT;
      r_pend <= DIR_RIGHT;
    end else if (bus.restart) begin
      r_dir  <= DIR_RIGHT;
      r_pend <= DIR_RIGHT;
    end else begin
      if (r_state == ST_STEP) r_dir <= r_pend;
      if (bus.dir_valid && (dir_e'(bus.dir_req) != reverse_of(r_dir))) r_pend <= dir_e'(bus.dir_req);
    end
  end

  // STEP captures the candidate head; CHECK resolves growth and collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nx_h <= '0;
      r_nx_v <= '0;
      r_wall <= 1'b0;
      r_hit  <= 1'b0;
      r_grow <= 1'b0;
      r_coll <= 1'b0;
    end else if (r_state == ST_STEP) begin
      r_nx_h <= w_nx_h;
      r_nx_v <= w_nx_v;
      r_wall <= w_wall;
    end else if (r_state == ST_CHECK) begin
      r_hit  <= w_hit;
      r_grow <= w_grow;
      r_coll <= w_coll;
    end
  end

  // COMMIT: move the head, update bitmap and length, or latch game over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_h <= XW'(GRID_W / 2);
      r_head_v <= YW'(GRID_H / 2);
      r_len    <= LW'(INIT_LEN);
      r_bitmap <= init_map();
      r_eaten  <= 1'b0;
      r_go     <= 1'b0;
    end else if (bus.restart) begin
      r_head_h <= XW'(GRID_W / 2);
      r_head_v <= YW'(GRID_H / 2);
      r_len    <= LW'(INIT_LEN);
      r_bitmap <= init_map();
      r_eaten  <= 1'b0;
      r_go     <= 1'b0;
    end else begin
      r_eaten <= 1'b0;
      if (r_state == ST_COMMIT) begin
        if (r_coll) begin
          r_go <= 1'b1;
        end else begin
          // Clear before set: moving into the vacating tail keeps the bit.
          if (!r_grow) r_bitmap[cell_idx(w_tail_h, w_tail_v)] <= 1'b0;
          r_bitmap[cell_idx(r_nx_h, r_nx_v)] <= 1'b1;
          r_head_h <= r_nx_h;
          r_head_v <= r_nx_v;
          if (r_grow) r_len <= r_len + 1'b1;
          r_eaten <= r_hit;
        end
      end
    end
  end

`ifdef SNEK_SCORE_EN
  logic [15:0] r_score;

  // Saturating count of eaten pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_score <= '0;
    else if (bus.restart)                       r_score <= '0;
    else if (w_commit_ok && r_hit && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
  end

  assign bus.score = r_score;
`endif

  assign w_q_in        = (int'(bus.query_h) < GRID_W) && (int'(bus.query_v) < GRID_H);
  assign bus.query_hit = w_q_in && r_bitmap[cell_idx(bus.query_h, bus.query_v)];
  assign bus.head_h    = r_head_h;
  assign bus.head_v    = r_head_v;
  assign bus.length    = r_len;
  assign bus.eaten     = r_eaten;
  assign bus.game_over = r_go;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snek_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_snek_engine
// Description : Bench for snek_engine. Two instances share one stimulus:
//               A = 32x24, MAX_LEN 64, wrapping; B = 32x24, MAX_LEN 8, walls.
//               A queue-free body-list model predicts each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snek_engine;
  import snek_pkg::*;

  localparam int GW  = 32;
  localparam int GH  = 24;
  localparam int XW  = 5;
  localparam int YW  = 5;
  localparam int LWA = 7;
  localparam int LWB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          tick, restart, dir_valid, food_valid;
  logic [1:0]    dir_req;
  logic [XW-1:0] food_h, query_h;
  logic [YW-1:0] food_v, query_v;

  snek_engine_if #(.XW(XW), .YW(YW), .LW(LWA)) if_a ();
  snek_engine_if #(.XW(XW), .YW(YW), .LW(LWB)) if_b ();

  assign if_a.tick = tick;             assign if_b.tick = tick;
  assign if_a.restart = restart;       assign if_b.restart = restart;
  assign if_a.dir_valid = dir_valid;   assign if_b.dir_valid = dir_valid;
  assign if_a.dir_req = dir_req;       assign if_b.dir_req = dir_req;
  assign if_a.food_valid = food_valid; assign if_b.food_valid = food_valid;
  assign if_a.food_h = food_h;         assign if_b.food_h = food_h;
  assign if_a.food_v = food_v;         assign if_b.food_v = food_v;
  assign if_a.query_h = query_h;       assign if_b.query_h = query_h;
  assign if_a.query_v = query_v;       assign if_b.query_v = query_v;

  snek_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(64), .INIT_LEN(3), .WRAP(1))
    u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  snek_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(8), .INIT_LEN(3), .WRAP(0))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  // ---------------- behavioural model: body list, head at index 0 ----------
  int P_MAX  [2] = '{64, 8};
  int P_WRAP [2] = '{1, 0};
  int bh [2][65];
  int bv [2][65];
  int mlen [2];
  int mdir [2];
  int mpend[2];
  int mcnt [2];
  bit mgo  [2];
  bit meat [2];

  function automatic void m_init(int w);
    mlen[w] = 3;
    for (int i = 0; i < 3; i++) begin
      bh[w][i] = GW / 2 - i;
      bv[w][i] = GH / 2;
    end
    mdir[w] = 1; mpend[w] = 1; mcnt[w] = 0; mgo[w] = 1'b0; meat[w] = 1'b0;
  endfunction

  function automatic bit m_occ(int w, int h, int v);
    for (int i = 0; i < mlen[w]; i++)
      if (bh[w][i] == h && bv[w][i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_step(int w);
    int nh, nv, th, tv;
    bit wall, hit, grow, coll;
    nh = bh[w][0]; nv = bv[w][0]; wall = 1'b0;
    case (mdir[w])
      0: nh = nh - 1;
      1: nh = nh + 1;
      2: nv = nv - 1;
      default: nv = nv + 1;
    endcase
    if (nh < 0 || nh >= GW || nv < 0 || nv >= GH) begin
      if (P_WRAP[w] != 0) begin
        nh = (nh + GW) % GW;
        nv = (nv + GH) % GH;
      end else begin
        wall = 1'b1;
      end
    end
    hit  = food_valid && nh == int'(food_h) && nv == int'(food_v);
    grow = hit && mlen[w] < P_MAX[w];
    th = bh[w][mlen[w] - 1]; tv = bv[w][mlen[w] - 1];
    coll = wall || (!wall && m_occ(w, nh, nv) && !(nh == th && nv == tv && !grow));
    if (coll) begin
      mgo[w] = 1'b1;
    end else begin
      for (int i = mlen[w]; i > 0; i--) begin
        bh[w][i] = bh[w][i - 1];
        bv[w][i] = bv[w][i - 1];
      end
      bh[w][0] = nh; bv[w][0] = nv;
      if (grow) mlen[w] = mlen[w] + 1;
    end
    meat[w] = hit && !coll;
  endfunction

  // One clock edge as seen by the model (inputs are stable around the edge).
  function automatic void m_edge(int w);
    meat[w] = 1'b0;
    if (dir_valid && int'(dir_req) != (mdir[w] ^ 1)) mpend[w] = int'(dir_req);
    if (mcnt[w] == 0) begin
      if (tick && !mgo[w]) begin
        mcnt[w] = 3;
        mdir[w] = mpend[w];
      end
    end else begin
      mcnt[w] = mcnt[w] - 1;
      if (mcnt[w] == 0) m_step(w);
    end
  endfunction

  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (!rst || restart) m_init(w);
      else                 m_edge(w);
    end
  end

  // ---------------- checking ------------------------------------------------
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic void cmp_inst(int w, string p, logic [31:0] hh, logic [31:0] hv,
                                   logic [31:0] len, logic [31:0] eat, logic [31:0] go,
                                   logic [31:0] bsy, logic [31:0] qh);
    chk({p, ".head_h"},    hh,  32'(bh[w][0]));
    chk({p, ".head_v"},    hv,  32'(bv[w][0]));
    chk({p, ".length"},    len, 32'(mlen[w]));
    chk({p, ".eaten"},     eat, 32'(meat[w]));
    chk({p, ".game_over"}, go,  32'(mgo[w]));
    chk({p, ".busy"},      bsy, 32'(mcnt[w] != 0));
    chk({p, ".query_hit"}, qh,  32'(m_occ(w, int'(query_h), int'(query_v))));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, "a", 32'(if_a.head_h), 32'(if_a.head_v), 32'(if_a.length), 32'(if_a.eaten),
               32'(if_a.game_over), 32'(if_a.busy), 32'(if_a.query_hit));
      cmp_inst(1, "b", 32'(if_b.head_h), 32'(if_b.head_v), 32'(if_b.length), 32'(if_b.eaten),
               32'(if_b.game_over), 32'(if_b.busy), 32'(if_b.query_hit));
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step1();
    @(posedge clk);
    #1;
    cyc++;
    query_h = XW'((cyc * 7) % GW);
    query_v = YW'(10 + cyc % 4);
  endtask

  // Returns just after the commit edge, while eaten is still high.
  task automatic do_tick();
    tick = 1'b1;
    step1();
    tick = 1'b0;
    repeat (3) step1();
  endtask

  task automatic set_dir(input int d);
    dir_valid = 1'b1;
    dir_req   = 2'(d);
    step1();
    dir_valid = 1'b0;
  endtask

  task automatic set_food(input bit v, input int h, input int y);
    food_valid = v;
    food_h     = XW'(h);
    food_v     = YW'(y);
  endtask

  task automatic qlit(input string nm, input int h, input int v, input int exp);
    query_h = XW'(h);
    query_v = YW'(v);
    #1;
    chk(nm, 32'(if_a.query_hit), 32'(exp));
  endtask

  task automatic uturn_setup();
    set_food(1'b1, 17, 12);
    do_tick();
    set_food(1'b0, 0, 0);
    set_dir(DIR_UP);
    do_tick();
    set_dir(DIR_LEFT);
    do_tick();
    set_dir(DIR_DOWN);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    rst = 1'b0; tick = 1'b0; restart = 1'b0; dir_valid = 1'b0; dir_req = 2'd0;
    food_valid = 1'b0; food_h = '0; food_v = '0; query_h = '0; query_v = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    chk("reset head_h", 32'(if_a.head_h), 16);
    chk("reset head_v", 32'(if_a.head_v), 12);
    chk("reset length", 32'(if_a.length), 3);
    chk("reset busy",   32'(if_a.busy), 0);

    do_tick();
    chk("tick1 head_h", 32'(if_a.head_h), 17);
    chk("tick1 head_v", 32'(if_a.head_v), 12);
    qlit("tick1 old tail freed", 14, 12, 0);
    qlit("tick1 tail occupied", 15, 12, 1);

    set_dir(DIR_LEFT);
    do_tick();
    chk("reversal dropped head_h", 32'(if_a.head_h), 18);

    set_dir(DIR_UP);
    do_tick();
    chk("turn up head_v", 32'(if_a.head_v), 11);

    set_dir(DIR_RIGHT);
    set_food(1'b1, 19, 11);
    do_tick();
    chk("eat eaten", 32'(if_a.eaten), 1);
    chk("eat length", 32'(if_a.length), 4);
    qlit("eat tail kept", 17, 12, 1);

    for (int h = 20; h <= 24; h++) begin
      set_food(1'b1, h, 11);
      do_tick();
    end
    chk("grow a length", 32'(if_a.length), 9);
    chk("full b length", 32'(if_b.length), 8);
    chk("full b eaten",  32'(if_b.eaten), 1);
    set_food(1'b0, 0, 0);

    repeat (7) do_tick();
    chk("edge a head_h", 32'(if_a.head_h), 31);
    do_tick();
    chk("wrap a head_h", 32'(if_a.head_h), 0);
    chk("wall b game_over", 32'(if_b.game_over), 1);
    chk("wall b head_h", 32'(if_b.head_h), 31);
    do_tick();
    chk("after wall a head_h", 32'(if_a.head_h), 1);
    chk("after wall b head_h", 32'(if_b.head_h), 31);

    restart = 1'b1;
    tick    = 1'b1;
    step1();
    restart = 1'b0;
    tick    = 1'b0;
    chk("restart head_h", 32'(if_a.head_h), 16);
    chk("restart length", 32'(if_a.length), 3);
    chk("restart busy",   32'(if_a.busy), 0);
    chk("restart b game_over", 32'(if_b.game_over), 0);

    tick = 1'b1;
    step1();
    tick = 1'b0;
    step1();
    restart = 1'b1;
    step1();
    restart = 1'b0;
    chk("abort busy", 32'(if_a.busy), 0);
    repeat (3) step1();
    chk("abort head_h", 32'(if_a.head_h), 16);

    uturn_setup();
    do_tick();
    chk("uturn tail game_over", 32'(if_a.game_over), 0);
    chk("uturn tail head_v", 32'(if_a.head_v), 12);

    restart = 1'b1;
    step1();
    restart = 1'b0;
    uturn_setup();
    set_food(1'b1, 16, 12);
    do_tick();
    chk("uturn food game_over", 32'(if_a.game_over), 1);
    chk("uturn food b game_over", 32'(if_b.game_over), 1);
    chk("uturn food eaten", 32'(if_a.eaten), 0);
    set_food(1'b0, 0, 0);
    do_tick();
    repeat (2) step1();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
